opb_status_bank: RTL and testbench

//  Multi-channel successor to the single-word simulink-to-PPC status register. Captures C_NUM_CH 32-bit user status words.

---
 rtl/opb_status_bank_pkg.sv | 40 ++++
 rtl/opb_status_bank_chan.sv | 54 +++++
 rtl/opb_status_bank.sv | 189 ++++++++++++++++++
 tb/tb_opb_status_bank.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/opb_status_bank_pkg.sv
// Shared offsets, FSM encoding and CTRL bit positions for the opb_status_bank OPB slave.
// Optional timestamp support in the top is controlled by OPB_STATUS_BANK_TSTAMP_EN.
package opb_status_bank_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned MAX_CH = 16;
  localparam int unsigned CNT_W  = 16;

  localparam logic [ADDR_W-1:0] OFF_CTRL      = 32'h0000_0000;
  localparam logic [ADDR_W-1:0] OFF_TSTAMP    = 32'h0000_0008;
  localparam logic [ADDR_W-1:0] OFF_CH_BASE   = 32'h0000_0010;
  localparam logic [ADDR_W-1:0] OFF_CH_STRIDE = 32'h0000_0008;
  localparam logic [ADDR_W-1:0] OFF_STICKY    = 32'h0000_0004;

  // CTRL bits as LSB-0 value positions: OPB bit 31 is value bit 0.
  localparam int unsigned CTRL_SNAP_BIT = 0;
  localparam int unsigned CTRL_CLR_BIT  = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACK  = 2'd1,
    ST_WAIT = 2'd2
  } opb_state_e;

  typedef struct packed {
    logic ctrl_wr;
    logic snap;
    logic clear;
  } ctrl_req_t;

  function automatic logic [ADDR_W-1:0] chan_offset(input int unsigned ch);
    return OFF_CH_BASE + OFF_CH_STRIDE * ADDR_W'(ch);
  endfunction

  function automatic logic [ADDR_W-1:0] window_last(input int unsigned num_ch);
    return chan_offset(num_ch) - 32'd1;
  endfunction

endpackage

// File: rtl/opb_status_bank_chan.sv
// One status channel: live capture, coherent snapshot copy and OR-accumulating sticky word.
// Snapshot always copies the pre-update live value; clear keeps a same-cycle event.
module opb_status_bank_chan
  import opb_status_bank_pkg::*;
#(
  parameter logic [DATA_W-1:0] STICKY_MASK = 32'hFFFF_FFFF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              valid_i,
  input  logic              snap_i,
  input  logic              clear_i,
  output logic [DATA_W-1:0] snap_o,
  output logic [DATA_W-1:0] sticky_o
);

  logic [DATA_W-1:0] live_q;
  logic [DATA_W-1:0] snap_q;
  logic [DATA_W-1:0] sticky_q;
  logic [DATA_W-1:0] sticky_d;
  logic [DATA_W-1:0] masked_c;

  assign masked_c = data_i & STICKY_MASK;

  always_comb begin
    sticky_d = sticky_q;
    if (clear_i) begin
      sticky_d = valid_i ? masked_c : '0;
    end else if (valid_i) begin
      sticky_d = sticky_q | masked_c;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      live_q   <= '0;
      snap_q   <= '0;
      sticky_q <= '0;
    end else begin
      if (valid_i) begin
        live_q <= data_i;
      end
      if (snap_i) begin
        snap_q <= live_q;
      end
      sticky_q <= sticky_d;
    end
  end

  assign snap_o   = snap_q;
  assign sticky_o = sticky_q;

endmodule

// File: rtl/opb_status_bank.sv
// Multi-channel status bank on one OPB slave window: CTRL, TSTAMP, per-channel SNAP/STICKY words.
// Define OPB_STATUS_BANK_TSTAMP_EN to add the free-running counter latched into TSTAMP on each snapshot.
module opb_status_bank
  import opb_status_bank_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR    = 32'h0100_8100,
  parameter logic [31:0] C_HIGHADDR    = 32'h0100_81FF,
  parameter int unsigned C_OPB_AWIDTH  = 32,
  parameter int unsigned C_OPB_DWIDTH  = 32,
  parameter int unsigned C_NUM_CH      = 4,
  parameter logic [31:0] C_STICKY_MASK = 32'hFFFF_FFFF
) (
  input  logic                       OPB_Clk,
  input  logic                       OPB_Rst,
  input  logic [0:C_OPB_AWIDTH-1]    OPB_ABus,
  input  logic [0:C_OPB_DWIDTH/8-1]  OPB_BE,
  input  logic [0:C_OPB_DWIDTH-1]    OPB_DBus,
  input  logic                       OPB_RNW,
  input  logic                       OPB_select,
  input  logic                       OPB_seqAddr,
  output logic [0:C_OPB_DWIDTH-1]    Sl_DBus,
  output logic                       Sl_xferAck,
  output logic                       Sl_errAck,
  output logic                       Sl_retry,
  output logic                       Sl_toutSup,
  input  logic [32*C_NUM_CH-1:0]     user_data_in,
  input  logic [C_NUM_CH-1:0]        user_valid
);

  if (C_OPB_DWIDTH != DATA_W || C_OPB_AWIDTH != ADDR_W) begin : g_err_width
    $error("opb_status_bank: only 32-bit OPB address and data are supported");
  end
  if (C_NUM_CH < 1 || C_NUM_CH > MAX_CH) begin : g_err_num_ch
    $error("opb_status_bank: C_NUM_CH must be 1..16");
  end
  if ((C_HIGHADDR < C_BASEADDR) || ((C_HIGHADDR - C_BASEADDR) < window_last(C_NUM_CH))) begin : g_err_window
    $error("opb_status_bank: C_HIGHADDR too small for C_NUM_CH channels");
  end

  logic [ADDR_W-1:0] abus_w;
  logic [DATA_W-1:0] wdata_w;
  logic [3:0]        be_w;
  logic [ADDR_W-1:0] off_c;
  logic [ADDR_W-1:0] off_word_c;
  logic              in_win_c;
  logic              ctrl_wr_c;
  logic [DATA_W-1:0] rd_data_c;
  logic [DATA_W-1:0] ctrl_rd_c;
  logic [DATA_W-1:0] tstamp_w;

  opb_state_e        state_q;
  logic              ack_q;
  logic [DATA_W-1:0] dbus_q;
  ctrl_req_t         req_q;

  logic              snap_c;
  logic              clr_c;
  logic [CNT_W-1:0]  snap_cnt_q;
  logic [CNT_W-1:0]  snap_cnt_d;

  logic [DATA_W-1:0] snap_w   [C_NUM_CH];
  logic [DATA_W-1:0] sticky_w [C_NUM_CH];

  // OPB [0:31] vectors land MSB-first, so value bit 0 is OPB bit 31 and be_w[0] is OPB_BE[3].
  assign abus_w  = OPB_ABus;
  assign wdata_w = OPB_DBus;
  assign be_w    = OPB_BE;

  assign in_win_c   = OPB_select && (abus_w >= C_BASEADDR) && (abus_w <= C_HIGHADDR);
  assign off_c      = abus_w - C_BASEADDR;
  assign off_word_c = {off_c[ADDR_W-1:2], 2'b00};
  assign ctrl_wr_c  = !OPB_RNW && (off_word_c == OFF_CTRL) && be_w[0];

  assign ctrl_rd_c = {8'(C_NUM_CH), 8'h00, snap_cnt_q};

  // Read mux over the register map; unmapped in-window words return zero.
  always_comb begin
    rd_data_c = '0;
    if (off_word_c == OFF_CTRL) begin
      rd_data_c = ctrl_rd_c;
    end else if (off_word_c == OFF_TSTAMP) begin
      rd_data_c = tstamp_w;
    end
    for (int unsigned ch = 0; ch < C_NUM_CH; ch++) begin
      if (off_word_c == chan_offset(ch)) begin
        rd_data_c = snap_w[ch];
      end
      if (off_word_c == (chan_offset(ch) + OFF_STICKY)) begin
        rd_data_c = sticky_w[ch];
      end
    end
  end

  // Handshake: ack on the second select cycle, then hold off until select drops.
  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) begin
      state_q <= ST_IDLE;
      ack_q   <= 1'b0;
      dbus_q  <= '0;
      req_q   <= '0;
    end else begin
      ack_q  <= 1'b0;
      dbus_q <= '0;
      unique case (state_q)
        ST_IDLE: begin
          if (in_win_c) begin
            state_q       <= ST_ACK;
            ack_q         <= 1'b1;
            dbus_q        <= OPB_RNW ? rd_data_c : '0;
            req_q.ctrl_wr <= ctrl_wr_c;
            req_q.snap    <= wdata_w[CTRL_SNAP_BIT];
            req_q.clear   <= wdata_w[CTRL_CLR_BIT];
          end
        end
        ST_ACK: begin
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          if (!OPB_select) begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign snap_c = (state_q == ST_ACK) && req_q.ctrl_wr && req_q.snap;
  assign clr_c  = (state_q == ST_ACK) && req_q.ctrl_wr && req_q.clear;

  assign snap_cnt_d = snap_c ? (snap_cnt_q + 16'd1) : snap_cnt_q;

  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) begin
      snap_cnt_q <= '0;
    end else begin
      snap_cnt_q <= snap_cnt_d;
    end
  end

`ifdef OPB_STATUS_BANK_TSTAMP_EN
  logic [DATA_W-1:0] free_cnt_q;
  logic [DATA_W-1:0] tstamp_q;

  // Free-running cycle counter, sampled into TSTAMP by each snapshot.
  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) begin
      free_cnt_q <= '0;
      tstamp_q   <= '0;
    end else begin
      free_cnt_q <= free_cnt_q + 32'd1;
      if (snap_c) begin
        tstamp_q <= free_cnt_q;
      end
    end
  end

  assign tstamp_w = tstamp_q;
`else
  assign tstamp_w = '0;
`endif

  for (genvar g = 0; g < int'(C_NUM_CH); g++) begin : g_chan
    opb_status_bank_chan #(
      .STICKY_MASK (C_STICKY_MASK)
    ) u_chan (
      .clk_i    (OPB_Clk),
      .rst_i    (OPB_Rst),
      .data_i   (user_data_in[32*g +: 32]),
      .valid_i  (user_valid[g]),
      .snap_i   (snap_c),
      .clear_i  (clr_c),
      .snap_o   (snap_w[g]),
      .sticky_o (sticky_w[g])
    );
  end

  assign Sl_DBus    = dbus_q;
  assign Sl_xferAck = ack_q;
  assign Sl_errAck  = 1'b0;
  assign Sl_retry   = 1'b0;
  assign Sl_toutSup = 1'b0;

  logic unused_ok;
  assign unused_ok = ^{OPB_seqAddr, be_w[3:1], wdata_w[DATA_W-1:2], off_c[1:0]};

endmodule

// File: tb/tb_opb_status_bank.sv
// Bench for opb_status_bank: directed register-map checks plus randomized OPB/user traffic
// compared every cycle against a register-level model. Honours OPB_STATUS_BANK_TSTAMP_EN.
`timescale 1ns/1ps
module tb_opb_status_bank;

  localparam int unsigned NCH  = 4;
  localparam logic [31:0] BASE = 32'h0100_8100;
  localparam logic [31:0] HIGH = 32'h0100_81FF;

  logic             clk = 1'b0;
  logic             rst;
  logic [0:31]      opb_abus;
  logic [0:3]       opb_be;
  logic [0:31]      opb_dbus;
  logic             opb_rnw;
  logic             opb_select;
  logic             opb_seqaddr;
  logic [0:31]      sl_dbus;
  logic             sl_xferack;
  logic             sl_errack;
  logic             sl_retry;
  logic             sl_toutsup;
  logic [32*NCH-1:0] user_data;
  logic [NCH-1:0]   user_valid;

  logic rand_en;
  logic chk_en;
  int   checks;
  int   failures;

  always #5 clk = ~clk;

  opb_status_bank #(
    .C_BASEADDR    (BASE),
    .C_HIGHADDR    (HIGH),
    .C_OPB_AWIDTH  (32),
    .C_OPB_DWIDTH  (32),
    .C_NUM_CH      (NCH),
    .C_STICKY_MASK (32'hFFFF_FFFF)
  ) dut (
    .OPB_Clk      (clk),
    .OPB_Rst      (rst),
    .OPB_ABus     (opb_abus),
    .OPB_BE       (opb_be),
    .OPB_DBus     (opb_dbus),
    .OPB_RNW      (opb_rnw),
    .OPB_select   (opb_select),
    .OPB_seqAddr  (opb_seqaddr),
    .Sl_DBus      (sl_dbus),
    .Sl_xferAck   (sl_xferack),
    .Sl_errAck    (sl_errack),
    .Sl_retry     (sl_retry),
    .Sl_toutSup   (sl_toutsup),
    .user_data_in (user_data),
    .user_valid   (user_valid)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%08h expected=%08h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_live   [NCH];
  logic [31:0] m_snap   [NCH];
  logic [31:0] m_sticky [NCH];
  logic [15:0] m_cnt;
  logic [31:0] m_tstamp;
  logic [31:0] m_cyc;
  logic        m_served;
  logic        m_ack;
  logic [31:0] m_dbus;
  logic        m_do_snap;
  logic        m_do_clr;

  function automatic logic in_win(input logic [31:0] a);
    return (a >= BASE) && (a <= HIGH);
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    logic [31:0] off;
    int ch;
    off = a - BASE;
    off = {off[31:2], 2'b00};
    if (off == 32'd0) return {8'(NCH), 8'h00, m_cnt};
`ifdef OPB_STATUS_BANK_TSTAMP_EN
    if (off == 32'd8) return m_tstamp;
`endif
    if (off >= 32'd16 && off < 32'(16 + 8 * NCH)) begin
      ch = int'((off - 32'd16) >> 3);
      return off[2] ? m_sticky[ch] : m_snap[ch];
    end
    return 32'd0;
  endfunction

  always @(posedge clk) begin : model
    logic        start;
    logic [31:0] rd;
    logic [31:0] dv;
    logic [31:0] ud;
    if (rst) begin
      for (int i = 0; i < int'(NCH); i++) begin
        m_live[i] = 0; m_snap[i] = 0; m_sticky[i] = 0;
      end
      m_cnt = 0; m_tstamp = 0; m_cyc = 0; m_served = 0;
      m_ack = 0; m_dbus = 0; m_do_snap = 0; m_do_clr = 0;
    end else begin
      start = opb_select && in_win(opb_abus) && !m_served;
      rd    = m_read(opb_abus);
      if (m_ack && m_do_snap) begin
        for (int i = 0; i < int'(NCH); i++) m_snap[i] = m_live[i];
        m_cnt    = m_cnt + 16'd1;
        m_tstamp = m_cyc;
      end
      for (int i = 0; i < int'(NCH); i++) begin
        ud = user_data[32*i +: 32];
        if (m_ack && m_do_clr) m_sticky[i] = user_valid[i] ? ud : 32'd0;
        else if (user_valid[i]) m_sticky[i] = m_sticky[i] | ud;
        if (user_valid[i]) m_live[i] = ud;
      end
      m_cyc = m_cyc + 32'd1;
      if (!opb_select) m_served = 0;
      dv = opb_dbus;
      if (start) begin
        m_served  = 1;
        m_do_snap = !opb_rnw && ((opb_abus - BASE) >> 2) == 32'd0 && opb_be[3] && dv[0];
        m_do_clr  = !opb_rnw && ((opb_abus - BASE) >> 2) == 32'd0 && opb_be[3] && dv[1];
      end else begin
        m_do_snap = 0;
        m_do_clr  = 0;
      end
      m_ack  = start;
      m_dbus = (start && opb_rnw) ? rd : 32'd0;
    end
  end

  // Cycle-by-cycle comparison of the slave outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("xferack", 32'(sl_xferack), 32'(m_ack));
      check("sl_dbus", sl_dbus, m_dbus);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(negedge clk);
    if (rand_en) begin
      for (int i = 0; i < int'(NCH); i++) begin
        user_valid[i] = ($urandom_range(0, 3) == 0);
        user_data[32*i +: 32] = 32'd1 << $urandom_range(0, 31);
      end
    end
  endtask

  task automatic xfer(input logic [31:0] addr, input logic rnw, input logic [0:3] be,
                      input logic [31:0] wd, input logic [NCH-1:0] inj_v, input logic [31:0] inj_d,
                      output logic got, output logic [31:0] rdata, output int lat);
    tick();
    opb_abus = addr; opb_rnw = rnw; opb_be = be; opb_dbus = wd; opb_select = 1'b1;
    got = 1'b0; rdata = 32'd0; lat = 0;
    for (int n = 1; n <= 8 && !got; n++) begin
      tick();
      if (sl_xferack) begin
        got = 1'b1; rdata = sl_dbus; lat = n;
        if (inj_v != '0) begin
          user_valid = inj_v;
          for (int i = 0; i < int'(NCH); i++) if (inj_v[i]) user_data[32*i +: 32] = inj_d;
        end
      end
    end
    tick();
    if (got) check("ack_width", 32'(sl_xferack), 32'd0);
    opb_select = 1'b0; opb_abus = '0; opb_dbus = '0; opb_be = '0; opb_rnw = 1'b1;
    if (!rand_en) user_valid = '0;
  endtask

  task automatic rd_expect(input string nm, input logic [31:0] addr, input logic [31:0] exp);
    logic got; logic [31:0] d; int lat;
    xfer(addr, 1'b1, 4'b0000, 32'd0, '0, 32'd0, got, d, lat);
    check({nm, "_ack"}, 32'(got), 32'd1);
    check(nm, d, exp);
  endtask

  task automatic wr(input string nm, input logic [31:0] addr, input logic [0:3] be,
                    input logic [31:0] wd, input logic [NCH-1:0] inj_v, input logic [31:0] inj_d);
    logic got; logic [31:0] d; int lat;
    xfer(addr, 1'b0, be, wd, inj_v, inj_d, got, d, lat);
    check({nm, "_ack"}, 32'(got), 32'd1);
  endtask

  task automatic pulse(input int ch, input logic [31:0] d);
    tick();
    user_valid[ch] = 1'b1;
    user_data[32*ch +: 32] = d;
    tick();
    user_valid = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        got;
    logic [31:0] d;
    logic [31:0] a;
    int          lat;
    logic        rnw;
    checks = 0; failures = 0;
    rst = 1'b1; rand_en = 1'b0; chk_en = 1'b0;
    opb_abus = '0; opb_be = '0; opb_dbus = '0; opb_rnw = 1'b1; opb_select = 1'b0; opb_seqaddr = 1'b0;
    user_data = '0; user_valid = '0;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    check("rst_ack", 32'(sl_xferack), 32'd0);
    check("rst_dbus", sl_dbus, 32'd0);
    check("tied_outputs", {29'd0, sl_errack, sl_retry, sl_toutsup}, 32'd0);
    rst = 1'b0;

    xfer(BASE, 1'b1, 4'b0000, 32'd0, '0, 32'd0, got, d, lat);
    check("ctrl_reset_read", d, 32'h0400_0000);
    check("ctrl_reset_latency", 32'(lat), 32'd1);

    pulse(1, 32'hDEAD_BEEF);
    wr("snap_a", BASE, 4'b0001, 32'h0000_0001, '0, 32'd0);
    rd_expect("snap1", BASE + 32'h18, 32'hDEAD_BEEF);
    rd_expect("ctrl_cnt1", BASE, 32'h0400_0001);

    pulse(0, 32'h1);
    pulse(0, 32'h4);
    rd_expect("sticky0_or", BASE + 32'h14, 32'h5);
    wr("clear", BASE, 4'b0001, 32'h0000_0002, 4'b0001, 32'h8);
    rd_expect("sticky0_clr_keep", BASE + 32'h14, 32'h8);

    pulse(2, 32'h11);
    wr("snap_b", BASE, 4'b0001, 32'h0000_0001, 4'b0100, 32'h77);
    rd_expect("snap2_pre_update", BASE + 32'h20, 32'h11);
    wr("snap_c", BASE, 4'b0001, 32'h0000_0001, '0, 32'd0);
    rd_expect("snap2_next", BASE + 32'h20, 32'h77);
    rd_expect("ctrl_cnt3", BASE, 32'h0400_0003);

    wr("snap_be_gated", BASE, 4'b1110, 32'h0000_0001, '0, 32'd0);
    rd_expect("ctrl_be_gated", BASE, 32'h0400_0003);

`ifdef OPB_STATUS_BANK_TSTAMP_EN
    rd_expect("tstamp", BASE + 32'h08, m_tstamp);
`else
    rd_expect("tstamp_off", BASE + 32'h08, 32'h0);
`endif

    rd_expect("hole_0c", BASE + 32'h0C, 32'h0);
    rd_expect("hole_30", BASE + 32'h30, 32'h0);
    wr("ro_write", BASE + 32'h10, 4'b1111, 32'h1234_5678, '0, 32'd0);
    rd_expect("ro_snap0", BASE + 32'h10, 32'h8);

    xfer(BASE + 32'h100, 1'b1, 4'b0000, 32'd0, '0, 32'd0, got, d, lat);
    check("oow_high_noack", 32'(got), 32'd0);
    xfer(BASE - 32'h4, 1'b1, 4'b0000, 32'd0, '0, 32'd0, got, d, lat);
    check("oow_low_noack", 32'(got), 32'd0);

    // Reset asserted in the first select cycle: the transfer is never acknowledged.
    tick();
    opb_abus = BASE; opb_rnw = 1'b1; opb_select = 1'b1; rst = 1'b1;
    tick();
    check("rst_mid_noack1", 32'(sl_xferack), 32'd0);
    tick();
    check("rst_mid_noack2", 32'(sl_xferack), 32'd0);
    rst = 1'b0; opb_select = 1'b0; opb_abus = '0;
    rd_expect("ctrl_after_rst", BASE, 32'h0400_0000);
    rd_expect("snap1_after_rst", BASE + 32'h18, 32'h0);

    rand_en = 1'b1;
    for (int t = 0; t < 120; t++) begin
      case ($urandom_range(0, 9))
        0:       a = BASE + 32'h100 + 32'(4 * $urandom_range(0, 3));
        1:       a = BASE - 32'(4 * $urandom_range(1, 4));
        2, 3, 4: a = BASE;
        default: a = BASE + 32'(4 * $urandom_range(0, 63));
      endcase
      rnw = ($urandom_range(0, 2) == 0);
      xfer(a, rnw, 4'($urandom_range(0, 15)), ($urandom & 32'hFFFF_FF00) | 32'($urandom_range(0, 3)),
           '0, 32'd0, got, d, lat);
      check("rand_ack", 32'(got), 32'(in_win(a)));
    end
    rand_en = 1'b0;
    user_valid = '0;
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
